prv32_mdu: RTL



---
 rtl/prv32_pkg.sv | 27 ++
 rtl/prv32_mdu_negate.sv | 12 +
 rtl/prv32_mdu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/prv32_pkg.sv
// Shared RV32M constants and MDU state encoding for the prv32 core.
// Optional feature macro used by prv32_mdu: PRV32_MDU_FAST_MUL_EN.
package prv32_pkg;

  localparam int XLEN = 32;

  // Opcode/funct7 pair the decoder matches to route M-extension ops to the MDU.
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/prv32_mdu_negate.sv
// Conditional two's-complement negator; width set by W.
module prv32_mdu_negate #(
  parameter int W = 32
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/prv32_mdu.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Optional macro PRV32_MDU_FAST_MUL_EN: single-cycle combinational multiply path.
module prv32_mdu #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] r,
  output logic [1:0]      dbg_state
);
  import prv32_pkg::*;

  // Handshake: start is accepted only in IDLE (busy=0) without flush; the
  // matching result is valid on r during the single cycle done=1.

  mdu_state_e          r_state, w_next;
  logic [2:0]          r_op;
  logic                r_neg, r_rem_neg;
  logic [XLEN-1:0]     r_opb, r_r;
  logic [2*XLEN-1:0]   r_prod;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic                w_b_zero, w_ovf, w_special, w_accept, w_fast_go;
  logic [XLEN-1:0]     w_special_r, w_fast_r, w_quo, w_rem, w_fix_r;
  logic [XLEN:0]       w_mul_sum, w_div_trial, w_div_diff;
  logic [2*XLEN-1:0]   w_mul_next, w_div_next, w_prod_fix;

  assign w_a_sgn = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign w_b_sgn = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_a_neg = w_a_sgn & a[XLEN-1];
  assign w_b_neg = w_b_sgn & b[XLEN-1];

  prv32_mdu_negate #(.W(XLEN)) u_neg_a (.i_neg(w_a_neg), .i_val(a), .o_val(w_a_mag));
  prv32_mdu_negate #(.W(XLEN)) u_neg_b (.i_neg(w_b_neg), .i_val(b), .o_val(w_b_mag));

  assign w_b_zero  = (b == '0);
  assign w_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign w_special = funct3[2] & (w_b_zero | w_ovf);
  assign w_accept  = (r_state == MDU_IDLE) && start && !flush;

  // funct3[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    w_special_r = '0;
    if (w_b_zero) w_special_r = funct3[1] ? a : '1;
    else          w_special_r = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef PRV32_MDU_FAST_MUL_EN
  logic signed [XLEN:0]     w_fa, w_fb;
  logic signed [2*XLEN-1:0] w_fp;
  assign w_fa      = {w_a_sgn & a[XLEN-1], a};
  assign w_fb      = {w_b_sgn & b[XLEN-1], b};
  assign w_fp      = w_fa * w_fb;
  assign w_fast_r  = (funct3 == F3_MUL) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
  assign w_fast_go = ~funct3[2];
`else
  assign w_fast_r  = '0;
  assign w_fast_go = 1'b0;
`endif

  // Multiply: upper half accumulates, multiplier consumed from bit 0.
  assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_prod[XLEN-1:1]};

  // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
  assign w_div_trial = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
  assign w_div_diff  = w_div_trial - {1'b0, r_opb};
  assign w_div_next  = w_div_diff[XLEN] ? {w_div_trial[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                                        : {w_div_diff[XLEN-1:0],  r_prod[XLEN-2:0], 1'b1};

  prv32_mdu_negate #(.W(2*XLEN)) u_neg_prod (.i_neg(r_neg), .i_val(r_prod), .o_val(w_prod_fix));
  prv32_mdu_negate #(.W(XLEN)) u_neg_quo (.i_neg(r_neg), .i_val(r_prod[XLEN-1:0]), .o_val(w_quo));
  prv32_mdu_negate #(.W(XLEN)) u_neg_rem (.i_neg(r_rem_neg), .i_val(r_prod[2*XLEN-1:XLEN]), .o_val(w_rem));

  always_comb begin
    w_fix_r = w_rem;
    case (r_op)
      F3_MUL:                        w_fix_r = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  w_fix_r = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:               w_fix_r = w_quo;
      default:                       w_fix_r = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MDU_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MDU_IDLE: if (start) w_next = (w_special || w_fast_go) ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_next = MDU_FIX;
      MDU_FIX:  w_next = MDU_DONE;
      MDU_DONE: w_next = MDU_IDLE;
      default:  w_next = MDU_IDLE;
    endcase
    if (flush) w_next = MDU_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_rem_neg <= 1'b0;
      r_opb     <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_r       <= '0;
    end else if (w_accept) begin
      r_op      <= funct3;
      r_neg     <= w_a_neg ^ w_b_neg;
      r_rem_neg <= w_a_neg;
      r_opb     <= w_b_mag;
      r_prod    <= {{XLEN{1'b0}}, w_a_mag};
      r_cnt     <= '0;
      if (w_special)      r_r <= w_special_r;
      else if (w_fast_go) r_r <= w_fast_r;
    end else if (!flush && r_state == MDU_CALC) begin
      r_prod <= r_op[2] ? w_div_next : w_mul_next;
      r_cnt  <= r_cnt + CNT_W'(1);
    end else if (!flush && r_state == MDU_FIX) begin
      r_r <= w_fix_r;
    end
  end

  assign busy      = (r_state != MDU_IDLE);
  assign done      = (r_state == MDU_DONE);
  assign r         = r_r;
  assign dbg_state = r_state;

endmodule
